// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bundle between the core datapath (master) and the hazard sequencer (slave).
// With PERF_COUNTERS_EN defined the bundle also carries the stall/flush performance counters.
interface hazard_sequencer_if
`ifdef PERF_COUNTERS_EN
   #(parameter int CNT_W = 16)
`endif
   ;

   logic       mem_read_dx;
   logic [4:0] rt_address_dx;
   logic [4:0] rs_address_fd;
   logic [4:0] rt_address_fd;
   logic       uses_rt_fd;
   logic       jump_fd;
   logic       pc_src;
   logic       dmem_busy;
   logic       halt_req;

   logic       pc_en;
   logic       fd_en;
   logic       fd_flush;
   logic       dx_flush;
   logic       xm_flush;
   logic       stall_all;
   logic       halted;
   logic [2:0] state;

`ifdef PERF_COUNTERS_EN
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
`endif

   modport master (
      output mem_read_dx, rt_address_dx, rs_address_fd, rt_address_fd, uses_rt_fd,
             jump_fd, pc_src, dmem_busy, halt_req,
      input  pc_en, fd_en, fd_flush, dx_flush, xm_flush, stall_all, halted, state
`ifdef PERF_COUNTERS_EN
      , input stall_count, flush_count
`endif
   );

   modport slave (
      input  mem_read_dx, rt_address_dx, rs_address_fd, rt_address_fd, uses_rt_fd,
             jump_fd, pc_src, dmem_busy, halt_req,
      output pc_en, fd_en, fd_flush, dx_flush, xm_flush, stall_all, halted, state
`ifdef PERF_COUNTERS_EN
      , output stall_count, flush_count
`endif
   );

endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer for the 5-stage core: load-use stalls, branch/jump flushes, memory wait, debug drain/halt.
// Optional macro PERF_COUNTERS_EN adds saturating stall/flush counters to the interface.
module hazard_sequencer #(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_sequencer_if.slave   hz
);

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_LU_STALL = 3'd1;
   localparam logic [2:0] ST_WAIT_MEM = 3'd2;
   localparam logic [2:0] ST_DRAIN    = 3'd3;
   localparam logic [2:0] ST_HALTED   = 3'd4;

   localparam logic [3:0] DRAIN_RELOAD = 4'(DRAIN_CYCLES - 1);

   typedef struct packed {
      logic pc_en;
      logic fd_en;
      logic fd_flush;
      logic dx_flush;
      logic xm_flush;
      logic stall_all;
      logic halted;
   } ctl_t;

   localparam ctl_t CTL_GO     = 7'b110_0000;
   localparam ctl_t CTL_FREEZE = 7'b000_0010;
   localparam ctl_t CTL_OFF    = 7'b000_0000;

   // Out-of-range parameters land in this scope so an external checker can flag them.
   if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || CNT_W < 1) begin : g_illegal_params
   end

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lu_s;
   ctl_t       run_ctl_s;
   logic [2:0] run_state_s;
   logic [3:0] run_cnt_s;
   ctl_t       ctl_s;

   assign lu_s = hz.mem_read_dx & (hz.rt_address_dx != 5'd0) &
                 ((hz.rt_address_dx == hz.rs_address_fd) |
                  (hz.uses_rt_fd & (hz.rt_address_dx == hz.rt_address_fd)));

   // Free-running pipeline decision, prioritised branch > memory > load-use > jump > halt.
   always_comb begin
      run_ctl_s   = CTL_GO;
      run_state_s = ST_RUN;
      run_cnt_s   = cnt_q;
      if (hz.pc_src) begin
         run_ctl_s.fd_flush = 1'b1;
         run_ctl_s.dx_flush = 1'b1;
         run_ctl_s.xm_flush = 1'b1;
      end else if (hz.dmem_busy) begin
         run_ctl_s   = CTL_FREEZE;
         run_state_s = ST_WAIT_MEM;
      end else if (lu_s) begin
         run_ctl_s.pc_en    = 1'b0;
         run_ctl_s.fd_en    = 1'b0;
         run_ctl_s.dx_flush = 1'b1;
         run_state_s        = ST_LU_STALL;
      end else if (hz.jump_fd) begin
         run_ctl_s.fd_flush = 1'b1;
      end else if (hz.halt_req) begin
         run_ctl_s.pc_en    = 1'b0;
         run_ctl_s.fd_flush = 1'b1;
         run_state_s        = ST_DRAIN;
         run_cnt_s          = DRAIN_RELOAD;
      end else begin
         run_state_s = ST_RUN;
      end
   end

   // Per-state output and next-state selection.
   always_comb begin
      ctl_s   = run_ctl_s;
      state_d = run_state_s;
      cnt_d   = run_cnt_s;
      case (state_q)
         ST_RUN, ST_LU_STALL: begin
            ctl_s   = run_ctl_s;
            state_d = run_state_s;
         end
         ST_WAIT_MEM: begin
            if (hz.dmem_busy) begin
               ctl_s   = CTL_FREEZE;
               state_d = ST_WAIT_MEM;
               cnt_d   = cnt_q;
            end else begin
               ctl_s   = run_ctl_s;
               state_d = run_state_s;
            end
         end
         ST_DRAIN: begin
            if (hz.dmem_busy) begin
               ctl_s   = CTL_FREEZE;
               state_d = ST_DRAIN;
               cnt_d   = cnt_q;
            end else begin
               ctl_s          = CTL_GO;
               ctl_s.pc_en    = hz.pc_src;
               ctl_s.fd_flush = 1'b1;
               ctl_s.dx_flush = hz.pc_src;
               ctl_s.xm_flush = hz.pc_src;
               if (!hz.halt_req) begin
                  state_d = ST_RUN;
                  cnt_d   = cnt_q;
               end else if (hz.pc_src) begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_RELOAD;
               end else if (cnt_q == 4'd0) begin
                  state_d = ST_HALTED;
                  cnt_d   = cnt_q;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = cnt_q - 4'd1;
               end
            end
         end
         ST_HALTED: begin
            ctl_s        = CTL_FREEZE;
            ctl_s.halted = 1'b1;
            cnt_d        = cnt_q;
            if (hz.halt_req) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            ctl_s   = CTL_OFF;
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // FSM state and drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces every control low straight away, independent of the clock.
   assign {hz.pc_en, hz.fd_en, hz.fd_flush, hz.dx_flush, hz.xm_flush, hz.stall_all, hz.halted} =
          rst_n ? ctl_s : CTL_OFF;
   assign hz.state = state_q;

`ifdef PERF_COUNTERS_EN
   logic             run_active_s;
   logic             stall_evt_s;
   logic             flush_evt_s;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   assign run_active_s = (state_q == ST_RUN) | (state_q == ST_LU_STALL) |
                         ((state_q == ST_WAIT_MEM) & ~hz.dmem_busy);
   assign stall_evt_s  = (state_q == ST_WAIT_MEM) |
                         (run_active_s & ~hz.pc_src & ~hz.dmem_busy & lu_s);
   assign flush_evt_s  = (run_active_s & (hz.pc_src | (~hz.dmem_busy & ~lu_s & hz.jump_fd))) |
                         ((state_q == ST_DRAIN) & ~hz.dmem_busy & hz.pc_src);

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (stall_evt_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
         if (flush_evt_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end else begin
            flush_cnt_q <= flush_cnt_q;
         end
      end
   end

   assign hz.stall_count = stall_cnt_q;
   assign hz.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: single-cycle decision table from RUN plus multi-cycle sequences.
module tb_hazard_sequencer;

   logic clk = 1'b0;
   logic rst_n;

`ifdef PERF_COUNTERS_EN
   hazard_sequencer_if #(.CNT_W(16)) hz ();
   hazard_sequencer #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`else
   hazard_sequencer_if hz ();
   hazard_sequencer #(.DRAIN_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       mr;
      logic [4:0] rt_dx;
      logic [4:0] rs_fd;
      logic [4:0] rt_fd;
      logic       uses_rt;
      logic       jump;
      logic       pc_src;
      logic       busy;
      logic       halt;
      logic [6:0] exp_out;   // {pc_en, fd_en, fd_flush, dx_flush, xm_flush, stall_all, halted}
      logic [2:0] exp_next;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string nm, input logic mr, input logic [4:0] rt_dx, input logic [4:0] rs_fd,
                      input logic [4:0] rt_fd, input logic uses_rt, input logic jump, input logic pc_src,
                      input logic busy, input logic halt, input logic [6:0] exp_out, input logic [2:0] exp_next);
      vec_t v;
      v.name = nm; v.mr = mr; v.rt_dx = rt_dx; v.rs_fd = rs_fd; v.rt_fd = rt_fd;
      v.uses_rt = uses_rt; v.jump = jump; v.pc_src = pc_src; v.busy = busy; v.halt = halt;
      v.exp_out = exp_out; v.exp_next = exp_next;
      vq.push_back(v);
   endtask

   function automatic logic [6:0] outs();
      return {hz.pc_en, hz.fd_en, hz.fd_flush, hz.dx_flush, hz.xm_flush, hz.stall_all, hz.halted};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      hz.mem_read_dx   = v.mr;
      hz.rt_address_dx = v.rt_dx;
      hz.rs_address_fd = v.rs_fd;
      hz.rt_address_fd = v.rt_fd;
      hz.uses_rt_fd    = v.uses_rt;
      hz.jump_fd       = v.jump;
      hz.pc_src        = v.pc_src;
      hz.dmem_busy     = v.busy;
      hz.halt_req      = v.halt;
   endtask

   task automatic idle();
      hz.mem_read_dx   = 1'b0;
      hz.rt_address_dx = 5'd0;
      hz.rs_address_fd = 5'd0;
      hz.rt_address_fd = 5'd0;
      hz.uses_rt_fd    = 1'b0;
      hz.jump_fd       = 1'b0;
      hz.pc_src        = 1'b0;
      hz.dmem_busy     = 1'b0;
      hz.halt_req      = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      add("idle",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b110_0000, 3'd0);
      add("lu_rs",    1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000, 3'd1);
      add("lu_r0",    1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b110_0000, 3'd0);
      add("lu_rt",    1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b000_1000, 3'd1);
      add("rt_nouse", 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b110_0000, 3'd0);
      add("no_load",  1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b110_0000, 3'd0);
      add("br_lu_j",  1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b111_1100, 3'd0);
      add("busy_lu",  1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b000_0010, 3'd2);
      add("lu_j",     1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b000_1000, 3'd1);
      add("jump",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b111_0000, 3'd0);
      add("halt",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b011_0000, 3'd3);
      add("halt_j",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b111_0000, 3'd0);
      add("br_busy",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b111_1100, 3'd0);
      add("halt_lu",  1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b000_1000, 3'd1);

      rst_n = 1'b0;
      idle();
      #1;
      check("reset_state", 32'(hz.state), 32'd0);
      check("reset_outs", 32'(outs()), 32'd0);
      #11;
      rst_n = 1'b1;
      #1;
      check("post_reset_outs", 32'(outs()), 32'h60);
      tick();

      // Each vector starts from RUN; one idle cycle returns every reachable state to RUN.
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         #2;
         check({vq[i].name, "_outs"}, 32'(outs()), 32'(vq[i].exp_out));
         tick();
         check({vq[i].name, "_next"}, 32'(hz.state), 32'(vq[i].exp_next));
         idle();
         tick();
         check({vq[i].name, "_back"}, 32'(hz.state), 32'd0);
      end

      // Load-use: one bubble cycle, then LU_STALL with RUN outputs, then RUN.
      hz.mem_read_dx = 1'b1; hz.rt_address_dx = 5'd8; hz.rs_address_fd = 5'd8;
      #2;
      check("lu_seq_outs", 32'(outs()), 32'h08);
      tick();
      check("lu_seq_st1", 32'(hz.state), 32'd1);
      idle();
      #2;
      check("lu_seq_stall_outs", 32'(outs()), 32'h60);
      tick();
      check("lu_seq_st0", 32'(hz.state), 32'd0);

      // Memory wait: busy for three cycles, a branch during the freeze is ignored.
      hz.dmem_busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         hz.pc_src = (c == 1) ? 1'b1 : 1'b0;
         #2;
         check("mem_freeze_outs", 32'(outs()), 32'h02);
         if (c > 0) check("mem_state", 32'(hz.state), 32'd2);
         tick();
      end
      idle();
      #2;
      check("mem_release_outs", 32'(outs()), 32'h60);
      check("mem_release_state", 32'(hz.state), 32'd2);
      tick();
      check("mem_back_run", 32'(hz.state), 32'd0);

      // Halt: entry cycle, four DRAIN cycles, then HALTED until halt_req drops.
      hz.halt_req = 1'b1;
      #2;
      check("halt_entry_outs", 32'(outs()), 32'h30);
      tick();
      for (int c = 0; c < 4; c++) begin
         check("drain_state", 32'(hz.state), 32'd3);
         check("drain_outs", 32'(outs()), 32'h30);
         tick();
      end
      check("halted_state", 32'(hz.state), 32'd4);
      check("halted_outs", 32'(outs()), 32'h03);
      tick();
      check("halted_hold", 32'(hz.state), 32'd4);
      hz.halt_req = 1'b0;
      tick();
      check("unhalt_state", 32'(hz.state), 32'd0);
      check("unhalt_outs", 32'(outs()), 32'h60);

      // Drain restart: branch in 2nd DRAIN cycle reloads the counter to DRAIN_CYCLES-1.
      hz.halt_req = 1'b1;
      tick();
      check("restart_d1", 32'(hz.state), 32'd3);
      tick();
      hz.pc_src = 1'b1;
      #2;
      check("restart_br_outs", 32'(outs()), 32'h7C);
      tick();
      hz.pc_src = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("restart_drain", 32'({hz.state, hz.halted}), 32'h6);
         tick();
      end
      check("restart_halted", 32'({hz.state, hz.halted}), 32'h9);
      hz.halt_req = 1'b0;
      tick();
      check("restart_back", 32'(hz.state), 32'd0);

      // Asynchronous reset while draining with counter at 2.
      hz.halt_req = 1'b1;
      tick();
      tick();
      check("rst_mid_pre", 32'(hz.state), 32'd3);
      hz.jump_fd = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_state", 32'(hz.state), 32'd0);
      check("rst_mid_outs", 32'(outs()), 32'd0);
      tick();
      check("rst_hold_outs", 32'(outs()), 32'd0);
      idle();
      rst_n = 1'b1;
      #2;
      check("rst_release_outs", 32'(outs()), 32'h60);
      tick();
      check("rst_release_state", 32'(hz.state), 32'd0);

`ifdef PERF_COUNTERS_EN
      // Counters were cleared by the reset above; one branch flush with LU and jump counts once.
      hz.pc_src = 1'b1; hz.jump_fd = 1'b1;
      hz.mem_read_dx = 1'b1; hz.rt_address_dx = 5'd8; hz.rs_address_fd = 5'd8;
      tick();
      idle();
      check("perf_flush_count", 32'(hz.flush_count), 32'd1);
      check("perf_stall_count", 32'(hz.stall_count), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control sequencer for the 5-stage MIPS-style core (fetch, decode, execute, memory, write-back).
- Decides every cycle whether each pipeline register advances, holds or is flushed:
  - load-use stalls
  - taken-branch flush (branch resolved in the memory stage)
  - jump flush in decode
  - multi-cycle data-memory wait
  - halt/drain handshake for debug
- Sits beside the forwarding unit and drives the PC and pipe-register enable/flush controls.

Parameters:
- DRAIN_CYCLES, 4: bubble cycles inserted after halt_req before halted asserts; legal range 1..15.
- CNT_W, 16: width of the performance counters (only used with PERF_COUNTERS_EN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mem_read_dx  input  1  instruction in execute is a load
- rt_address_dx  input  5  load destination register in execute
- rs_address_fd  input  5  rs field of the instruction in decode
- rt_address_fd  input  5  rt field of the instruction in decode
- uses_rt_fd  input  1  decode instruction reads rt (R-type, store, beq)
- jump_fd  input  1  jump decoded in decode stage
- pc_src  input  1  branch taken, from the memory stage
- dmem_busy  input  1  data memory not ready; pipeline must freeze
- halt_req  input  1  debug halt request, level-sensitive
- pc_en  output  1  PC register loads next PC
- fd_en  output  1  fetch/decode register loads
- fd_flush  output  1  fetch/decode register loads a NOP
- dx_flush  output  1  decode/execute control bits forced to 0
- xm_flush  output  1  execute/memory control bits forced to 0
- stall_all  output  1  freeze the DX, XM and MW registers
- halted  output  1  pipeline drained and stopped
- state  output  3  current FSM state code

Behaviour:
- State is registered; all outputs except state are Mealy (state plus current inputs).
- State codes:
  - RUN=0
  - LU_STALL=1
  - WAIT_MEM=2
  - DRAIN=3
  - HALTED=4
- Reset (rst_n low, asynchronous):
  - state=RUN, drain counter=0.
  - All outputs 0, including pc_en and fd_en.
  - After release, outputs follow the RUN rules.
- Default (RUN, no event): pc_en=1, fd_en=1, all flushes 0, stall_all=0, halted=0.
- Load-use hazard:
  - LU = mem_read_dx & (rt_address_dx!=0) & ((rt_address_dx==rs_address_fd) | (uses_rt_fd & rt_address_dx==rt_address_fd)).
- RUN priority, highest first:
  1. pc_src: fd_flush=dx_flush=xm_flush=1, pc_en=1 (loads branch target). Stay in RUN.
  2. dmem_busy: pc_en=0, fd_en=0, stall_all=1. Go to WAIT_MEM.
  3. LU: pc_en=0, fd_en=0, dx_flush=1 (one bubble). Go to LU_STALL.
  4. jump_fd: fd_flush=1. Stay in RUN.
  5. halt_req: go to DRAIN, counter=DRAIN_CYCLES-1, fd_flush=1, pc_en=0.
- LU_STALL:
  - Exactly one cycle; outputs follow RUN rules.
  - Next state RUN, unless dmem_busy (WAIT_MEM).
  - A second LU in this cycle is handled again: back to LU_STALL.
- WAIT_MEM:
  - pc_en=0, fd_en=0, stall_all=1, no flushes.
  - Leave when dmem_busy=0; outputs that cycle follow RUN rules and the next state is the RUN transition.
  - pc_src is not sampled while frozen.
- DRAIN, per cycle:
  - pc_en=0, fd_en=1, fd_flush=1.
  - Counter decrements; at 0, go to HALTED.
  - pc_src: also dx_flush=xm_flush=1, pc_en=1, counter reloads to DRAIN_CYCLES-1.
  - dmem_busy: freeze as in WAIT_MEM; counter holds.
  - halt_req deasserted: return to RUN next cycle.
- HALTED:
  - pc_en=0, fd_en=0, stall_all=1, halted=1.
  - halt_req=0 returns to RUN; the first RUN cycle has halted=0.
- LU never fires in DRAIN or HALTED: bubbles carry no load.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
- Defined:
  - Adds outputs stall_count[CNT_W-1:0] (increments on LU and on each WAIT_MEM cycle) and flush_count[CNT_W-1:0] (increments on each pc_src or jump flush).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst_n low while state=DRAIN with counter=2.
  - Required: state=0 and all outputs 0 immediately, asynchronously.
  - After release, with no events: pc_en=1, fd_en=1.
- Load-use:
  - Stimulus: mem_read_dx=1, rt_address_dx=8, rs_address_fd=8.
  - Required: one cycle with pc_en=0, fd_en=0, dx_flush=1, then state=1, then state=0.
  - Stimulus: rt_address_dx=0.
  - Required: no stall.
- Taken branch plus simultaneous LU and jump_fd:
  - Required: only the flush triple fd/dx/xm=1 and pc_en=1.
  - Required: state stays 0.
  - Required (PERF_COUNTERS_EN): flush_count increments by 1.
- Memory wait:
  - Stimulus: dmem_busy high for 3 cycles.
  - Required: stall_all=1 and pc_en=0 for exactly those 3 cycles, state=2.
  - Required: normal enables on the cycle busy drops.
- Halt:
  - Stimulus: halt_req=1 with DRAIN_CYCLES=4.
  - Required: 4 DRAIN cycles with fd_flush=1, then halted=1.
  - Stimulus: drop halt_req.
  - Required: state=0 and halted=0 next cycle.
- Drain restart:
  - Stimulus: pc_src during the 2nd DRAIN cycle.
  - Required: pc_en=1 and all flushes 1.
  - Required: halted asserts 4 cycles after that event.
